// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer driving one shared external half-adder cell.
// Each operand bit uses two half-adder passes (P1: a^b, P2: partial sum ^ carry).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ha_a,
    output logic             ha_b,
    input  logic             ha_sum,
    input  logic             ha_carry,
    output logic [1:0]       dbg_state_o
);

    // Handshake: start is a request sampled only while idle (no queueing);
    // done is a one-cycle pulse marking result/cout as freshly updated.

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             c_q, c_d;
    logic             s1_q, s1_d;
    logic             c1_q, c1_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            result_q <= '0;
            idx_q    <= '0;
            c_q      <= 1'b0;
            s1_q     <= 1'b0;
            c1_q     <= 1'b0;
            cout_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            c_q      <= c_d;
            s1_q     <= s1_d;
            c1_q     <= c1_d;
            cout_q   <= cout_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        result_d = result_q;
        idx_d    = idx_q;
        c_d      = c_q;
        s1_d     = s1_q;
        c1_d     = c1_q;
        cout_d   = cout_q;
        done_d   = 1'b0;
        ha_a     = 1'b0;
        ha_b     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = P1;
                    a_d     = op_a;
                    b_d     = op_b;
                    c_d     = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            P1: begin
                ha_a    = a_q[idx_q];
                ha_b    = b_q[idx_q];
                s1_d    = ha_sum;
                c1_d    = ha_carry;
                state_d = P2;
            end
            P2: begin
                ha_a         = s1_q;
                ha_b         = c_q;
                sum_d[idx_q] = ha_sum;
                // c1_q and ha_carry cannot both be set, so OR is the exact carry
                c_d          = c1_q | ha_carry;
                idx_d        = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d  = DONE;
                    result_d = sum_d;
                    cout_d   = c_d;
                    done_d   = 1'b1;
                end else begin
                    state_d = P1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign cout        = cout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with an external half-adder model and
// a queue of expected {cout, result} values consumed on every done pulse.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             cin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ha_a;
    logic             ha_b;
    logic             ha_sum;
    logic             ha_carry;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [WIDTH:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .cout        (cout),
        .ha_a        (ha_a),
        .ha_b        (ha_b),
        .ha_sum      (ha_sum),
        .ha_carry    (ha_carry),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    assign ha_sum   = ha_a ^ ha_b;
    assign ha_carry = ha_a & ha_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            check("done_has_expect", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                logic [WIDTH:0] e;
                e = exp_q.pop_front();
                check("result", 32'(result), 32'(e[WIDTH-1:0]));
                check("cout", 32'(cout), 32'(e[WIDTH]));
            end
        end
    end

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic c);
        return (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(c);
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic c, input bit push);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        if (push) exp_q.push_back(model(a, b, c));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done, then steps one more edge so the DUT is idle again.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_n++;
        end
        @(posedge clk);
        #1;
        if (busy) busy_n++;
    endtask

    task automatic run_add(input string tag, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic c);
        int lat;
        int bn;
        drive_start(a, b, c, 1'b1);
        wait_done(lat, bn);
        check({tag, "_latency"}, 32'(lat), 32'(2*WIDTH));
    endtask

    initial begin
        int lat;
        int bn;
        int n;
        int base;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic rc;

        // reset values
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", 32'(result), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_ha_a", 32'(ha_a), 0);
        check("rst_ha_b", 32'(ha_b), 0);
        check("rst_state", 32'(dbg_state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic add with latency and busy width
        drive_start(8'h5A, 8'h3C, 1'b0, 1'b1);
        wait_done(lat, bn);
        check("basic_latency", 32'(lat), 16);
        check("basic_busy_cycles", 32'(bn), 17);

        // carry chains
        run_add("carry1", 8'hFF, 8'h01, 1'b0);
        run_add("carry2", 8'hFF, 8'h00, 1'b1);

        // datapath sequencing on the half-adder port
        drive_start(8'h01, 8'h01, 1'b0, 1'b1);
        check("p1_ha_a", 32'(ha_a), 1);
        check("p1_ha_b", 32'(ha_b), 1);
        @(posedge clk);
        #1;
        check("p2_ha_a", 32'(ha_a), 0);
        check("p2_ha_b", 32'(ha_b), 0);
        wait_done(lat, bn);
        check("seq_latency", 32'(lat), 15);

        // start while busy is ignored
        base = done_cnt;
        drive_start(8'h10, 8'h20, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        drive_start(8'hFF, 8'hFF, 1'b0, 1'b0);
        wait_done(lat, bn);
        check("busy_start_latency", 32'(lat), 7);
        repeat (30) @(posedge clk);
        #1;
        check("busy_start_single_done", 32'(done_cnt - base), 1);
        check("busy_start_idle", 32'(busy), 0);

        // start held high: repeating done every 18 cycles
        base = done_cnt;
        op_a  = 8'h33;
        op_b  = 8'h44;
        cin   = 1'b1;
        start = 1'b1;
        repeat (3) exp_q.push_back(model(8'h33, 8'h44, 1'b1));
        @(posedge clk);
        #1;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("held_first_latency", 32'(n), 16);
        for (int i = 0; i < 2; i++) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!done && n < 200);
            check("held_interval", 32'(n), 18);
        end
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("held_done_count", 32'(done_cnt - base), 3);

        // asynchronous reset mid-operation
        base = done_cnt;
        drive_start(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_result", 32'(result), 0);
        check("mid_rst_cout", 32'(cout), 0);
        check("mid_rst_ha_a", 32'(ha_a), 0);
        check("mid_rst_ha_b", 32'(ha_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_no_done", 32'(done_cnt - base), 0);
        check("post_rst_idle", 32'(busy), 0);
        run_add("post_rst_add", 8'h7F, 8'h01, 1'b0);

        // random operands
        for (int i = 0; i < 6; i++) begin
            ra = WIDTH'($urandom_range(0, 255));
            rb = WIDTH'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            run_add("random", ra, rb, rc);
        end

        repeat (5) @(posedge clk);
        #1;
        check("expect_queue_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
